// File: rtl/jts16_sndcmd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : jts16_snd_pkg                                               |
// | Purpose  : Shared definitions for the System 16A sound command channel:|
// |            status byte bit positions, NMI / ack FSM state types and    |
// |            default timing constants.                                   |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package jts16_snd_pkg;

    // Status byte layout: {pending, overrun, ack_busy, 0, level[3:0]}
    localparam int c_stat_pend_bit = 7;
    localparam int c_stat_ovr_bit  = 6;
    localparam int c_stat_ack_bit  = 5;
    localparam int c_stat_lvl_lsb  = 0;

    // Default acknowledge length in snd_cen ticks
    localparam int c_def_ack_len   = 4;

    // NMI stays released this many snd_cen ticks between queued commands
    localparam int c_nmi_gap_ticks = 2;

    typedef enum logic [1:0] {
        N_IDLE   = 2'd0,
        N_ASSERT = 2'd1,
        N_GAP    = 2'd2
    } nmi_state_t;

    typedef enum logic [0:0] {
        A_IDLE = 1'b0,
        A_HOLD = 1'b1
    } ack_state_t;

endpackage

`default_nettype wire

// File: rtl/jts16_sndcmd_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : jts16_sndcmd_fifo                                           |
// | Purpose  : Small synchronous FIFO holding queued sound commands.       |
// |            Head entry is presented combinationally on 'head'.          |
// | Ports    : clk, rst (async, active-high), push, pop, din[WIDTH],       |
// |            head[WIDTH], level[log2(DEPTH):0], full, empty              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module jts16_sndcmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw:0]     r_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty = (r_level == '0);
    assign full  = (r_level == (c_aw+1)'(DEPTH));
    assign level = r_level;
    assign head  = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only if a pop frees a slot on the same clk
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/jts16_sndcmd.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : jts16_sndcmd                                                |
// | Purpose  : Sound-CPU end of the System 16A main->sound command channel.|
// |            Captures the command on the falling edge of snd_irqn, holds |
// |            it for the Z80, drives the Z80 NMI and returns an ack pulse |
// |            once the command has been read.                             |
// | Ports    : clk, rst (async, active-high), snd_cen, snd_latch[8],       |
// |            snd_irqn, snd_ack, cmd_cs, stat_cs, rd_n, dout[8], nmi_n    |
// | Config   : JTS16_SNDCMD_FIFO_EN - queue commands in a FIFO_DEPTH FIFO  |
// |            instead of a single overwrite-on-overrun latch.             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module jts16_sndcmd
    import jts16_snd_pkg::*;
#(
    parameter int ACK_LEN    = c_def_ack_len,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       snd_cen,
    input  logic [7:0] snd_latch,
    input  logic       snd_irqn,
    output logic       snd_ack,
    input  logic       cmd_cs,
    input  logic       stat_cs,
    input  logic       rd_n,
    output logic [7:0] dout,
    output logic       nmi_n
);

    if (ACK_LEN < 1 || ACK_LEN > 15) begin : g_chk_ack_len
        $error("jts16_sndcmd: ACK_LEN must be 1..15");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_chk_depth
        $error("jts16_sndcmd: FIFO_DEPTH must be a power of two in 2..8");
    end

    // ---------------------------------------------------------------------
    // Request edge detect and Z80 read tracking
    // ---------------------------------------------------------------------
    logic r_irqn_last;
    logic r_rd_cmd;
    logic r_rd_stat;
    logic w_capture;
    logic w_rd_cmd;
    logic w_rd_stat;
    logic w_cmd_done;
    logic w_stat_done;

    assign w_capture   = r_irqn_last & ~snd_irqn;
    assign w_rd_cmd    = cmd_cs & ~rd_n;
    assign w_rd_stat   = stat_cs & ~rd_n;
    // A read completes on the first clk its select/strobe term drops
    assign w_cmd_done  = r_rd_cmd & ~w_rd_cmd;
    assign w_stat_done = r_rd_stat & ~w_rd_stat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irqn_last <= 1'b1;
            r_rd_cmd    <= 1'b0;
            r_rd_stat   <= 1'b0;
        end else begin
            r_irqn_last <= snd_irqn;
            r_rd_cmd    <= w_rd_cmd;
            r_rd_stat   <= w_rd_stat;
        end
    end

    // ---------------------------------------------------------------------
    // Command storage
    // ---------------------------------------------------------------------
    logic       w_pending;
    logic [7:0] w_head;
    logic [3:0] w_level;
    logic       w_drop;

`ifdef JTS16_SNDCMD_FIFO_EN
    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [7:0]         w_fifo_head;
    logic [c_lvl_w-1:0] w_fifo_level;

    assign w_pop  = w_cmd_done & ~w_empty;
    // A capture that finds the FIFO full with no pop on the same clk is lost
    assign w_drop = w_capture & w_full & ~w_pop;

    jts16_sndcmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_capture),
        .pop   (w_pop),
        .din   (snd_latch),
        .head  (w_fifo_head),
        .level (w_fifo_level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_pending = ~w_empty;
    assign w_head    = w_empty ? 8'hFF : w_fifo_head;
    assign w_level   = 4'(w_fifo_level);
`else
    logic [7:0] r_cmd;
    logic       r_pending;

    // Capture has priority over read completion: the new byte stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd     <= 8'hFF;
            r_pending <= 1'b0;
        end else if (w_capture) begin
            r_cmd     <= snd_latch;
            r_pending <= 1'b1;
        end else if (w_cmd_done) begin
            r_pending <= 1'b0;
        end
    end

    // Overwriting an unread command is an overrun; replacing one being
    // consumed on the same clk is not
    assign w_drop    = w_capture & r_pending & ~w_cmd_done;
    assign w_pending = r_pending;
    assign w_head    = r_cmd;
    assign w_level   = {3'b000, r_pending};
`endif

    logic r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (w_stat_done) begin
            r_overrun <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Ack FSM
    // ---------------------------------------------------------------------
    ack_state_t r_ack_state;
    ack_state_t w_ack_next;
    logic [3:0] r_ack_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_state <= A_IDLE;
            r_ack_cnt   <= '0;
        end else begin
            r_ack_state <= w_ack_next;
            // Every completion (re)loads the counter, stretching a live pulse
            if (w_cmd_done) begin
                r_ack_cnt <= 4'(ACK_LEN);
            end else if (r_ack_state == A_HOLD && snd_cen) begin
                r_ack_cnt <= r_ack_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_ack_next = r_ack_state;
        snd_ack    = 1'b0;
        case (r_ack_state)
            A_IDLE: begin
                if (w_cmd_done) w_ack_next = A_HOLD;
            end
            A_HOLD: begin
                snd_ack = 1'b1;
                if (!w_cmd_done && snd_cen && r_ack_cnt == 4'd1) w_ack_next = A_IDLE;
            end
            default: w_ack_next = A_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // NMI FSM
    // ---------------------------------------------------------------------
    nmi_state_t r_nmi_state;
    nmi_state_t w_nmi_next;
    logic [1:0] r_gap_cnt;
    logic       w_gap_last;

    assign w_gap_last = snd_cen && (r_gap_cnt == 2'(c_nmi_gap_ticks - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_state <= N_IDLE;
            r_gap_cnt   <= '0;
        end else begin
            r_nmi_state <= w_nmi_next;
            if (r_nmi_state != N_GAP) begin
                r_gap_cnt <= '0;
            end else if (snd_cen) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_nmi_next = r_nmi_state;
        nmi_n      = 1'b1;
        case (r_nmi_state)
            N_IDLE: begin
                if (w_pending) w_nmi_next = N_ASSERT;
            end
            N_ASSERT: begin
                nmi_n = 1'b0;
                if (w_cmd_done) w_nmi_next = N_GAP;
            end
            N_GAP: begin
                // Released gap gives the Z80 a fresh NMI edge per queued command
                if (w_gap_last) w_nmi_next = w_pending ? N_ASSERT : N_IDLE;
            end
            default: w_nmi_next = N_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Z80 data bus
    // ---------------------------------------------------------------------
    logic [7:0] w_status;

    always_comb begin
        w_status                                     = 8'h00;
        w_status[c_stat_pend_bit]                    = w_pending;
        w_status[c_stat_ovr_bit]                     = r_overrun;
        w_status[c_stat_ack_bit]                     = (r_ack_state == A_HOLD);
        w_status[c_stat_lvl_lsb +: 4]                = w_level;
    end

    // The byte is sampled when a read starts and frozen until the read ends,
    // so a capture mid-read cannot change what the Z80 sees
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 8'hFF;
        end else if (w_rd_cmd) begin
            if (!r_rd_cmd) dout <= w_head;
        end else if (w_rd_stat) begin
            if (!r_rd_stat) dout <= w_status;
        end else begin
            dout <= 8'hFF;
        end
    end

endmodule

`default_nettype wire
